// File: rtl/pe_net_iface.sv
// rtl/pe_net_iface.sv - PE to network-switch endpoint with tx/rx flit FIFOs and statistics
//
// pe_net_fifo : registered-output FIFO used for both directions.
//    i_clk, i_reset             clock, asynchronous active-low reset
//    i_wrData, i_wrEn           push side (push ignored when full)
//    o_notFull                  registered "room available"
//    o_headData, o_headValid    registered head entry and non-empty flag
//    i_rdEn                     pop head (ignored when empty)
//
// pe_net_iface : endpoint between a processing element and one switch port.
//    i_sclk, i_reset                        clock, asynchronous active-low reset
//    i_pe_dest, i_pe_payload                tx word from the PE
//    i_pe_valid / o_pe_ready                PE tx handshake
//    o_net_data / o_net_valid / i_net_ready flit toward the switch
//    i_net_data / i_net_valid / o_net_ready flit from the switch
//    o_pe_rx_payload / o_pe_rx_valid / i_pe_rx_ready  PE rx handshake
//    o_tx_count, o_rx_count, o_misroute_count         statistics
//
// Build option: PE_NET_IFACE_STATS_EN builds the saturating statistics
// counters; without it the count outputs are tied to zero.

module pe_net_fifo #(
   parameter int Width = 32,
   parameter int Depth = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [Width-1:0] i_wrData,
   input  logic             i_wrEn,
   output logic             o_notFull,
   output logic [Width-1:0] o_headData,
   output logic             o_headValid,
   input  logic             i_rdEn
);
   localparam int PtrW = $clog2(Depth);

   logic [Width-1:0] mem [Depth];
   logic [PtrW-1:0]  wrPtr;
   logic [PtrW-1:0]  rdPtr;
   logic [PtrW-1:0]  nextRd;
   logic [PtrW:0]    count;
   logic [PtrW:0]    nextCount;
   logic             push;
   logic             pop;

   // Gating on the registered flags means a full FIFO never accepts a word
   // in the same cycle it releases one.
   assign push = i_wrEn && o_notFull;
   assign pop  = i_rdEn && o_headValid;

   always_comb begin
      nextRd    = rdPtr + PtrW'(pop);
      nextCount = count + (PtrW+1)'(push) - (PtrW+1)'(pop);
   end

   // Storage needs no reset: the head register only ever loads written entries.
   always_ff @(posedge i_clk) begin
      if (push) begin
         mem[wrPtr] <= i_wrData;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         wrPtr       <= '0;
         rdPtr       <= '0;
         count       <= '0;
         o_notFull   <= 1'b0;
         o_headValid <= 1'b0;
         o_headData  <= '0;
      end else begin
         wrPtr       <= wrPtr + PtrW'(push);
         rdPtr       <= nextRd;
         count       <= nextCount;
         o_notFull   <= (nextCount != (PtrW+1)'(Depth));
         o_headValid <= (nextCount != '0);
         // Head after this edge: a word written into the slot that becomes
         // the head is forwarded directly, giving one-cycle latency.
         if (nextCount == '0) begin
            o_headData <= '0;
         end else if (push && (wrPtr == nextRd)) begin
            o_headData <= i_wrData;
         end else begin
            o_headData <= mem[nextRd];
         end
      end
   end
endmodule

module pe_net_iface #(
   parameter int DataWidth = 36,
   parameter int AddrWidth = 4,
   parameter int MyAddr    = 0,
   parameter int TxDepth   = 4,
   parameter int RxDepth   = 4
) (
   input  logic                           i_sclk,
   input  logic                           i_reset,
   input  logic [AddrWidth-1:0]           i_pe_dest,
   input  logic [DataWidth-AddrWidth-1:0] i_pe_payload,
   input  logic                           i_pe_valid,
   output logic                           o_pe_ready,
   output logic [DataWidth-1:0]           o_net_data,
   output logic                           o_net_valid,
   input  logic                           i_net_ready,
   input  logic [DataWidth-1:0]           i_net_data,
   input  logic                           i_net_valid,
   output logic                           o_net_ready,
   output logic [DataWidth-AddrWidth-1:0] o_pe_rx_payload,
   output logic                           o_pe_rx_valid,
   input  logic                           i_pe_rx_ready,
   output logic [15:0]                    o_tx_count,
   output logic [15:0]                    o_rx_count,
   output logic [15:0]                    o_misroute_count
);
   localparam int PayW = DataWidth - AddrWidth;

   logic addrMatch;
   logic rxMatchFire;

   assign addrMatch   = (i_net_data[DataWidth-1 -: AddrWidth] == AddrWidth'(MyAddr));
   // Every offered flit is accepted while there is room; only matching
   // flits are stored, the rest are dropped.
   assign rxMatchFire = i_net_valid && o_net_ready && addrMatch;

   pe_net_fifo #(.Width(DataWidth), .Depth(TxDepth)) txFifo (
      .i_clk       (i_sclk),
      .i_reset     (i_reset),
      .i_wrData    ({i_pe_dest, i_pe_payload}),
      .i_wrEn      (i_pe_valid),
      .o_notFull   (o_pe_ready),
      .o_headData  (o_net_data),
      .o_headValid (o_net_valid),
      .i_rdEn      (i_net_ready)
   );

   pe_net_fifo #(.Width(PayW), .Depth(RxDepth)) rxFifo (
      .i_clk       (i_sclk),
      .i_reset     (i_reset),
      .i_wrData    (i_net_data[PayW-1:0]),
      .i_wrEn      (rxMatchFire),
      .o_notFull   (o_net_ready),
      .o_headData  (o_pe_rx_payload),
      .o_headValid (o_pe_rx_valid),
      .i_rdEn      (i_pe_rx_ready)
   );

`ifdef PE_NET_IFACE_STATS_EN
   logic        txFire;
   logic        misFire;
   logic [15:0] txCount;
   logic [15:0] rxCount;
   logic [15:0] misCount;

   assign txFire  = o_net_valid && i_net_ready;
   assign misFire = i_net_valid && o_net_ready && !addrMatch;

   // Counters stick at all-ones rather than wrapping.
   always_ff @(posedge i_sclk or negedge i_reset) begin
      if (!i_reset) begin
         txCount  <= '0;
         rxCount  <= '0;
         misCount <= '0;
      end else begin
         if (txFire && (txCount != 16'hFFFF)) begin
            txCount <= txCount + 16'd1;
         end
         if (rxMatchFire && (rxCount != 16'hFFFF)) begin
            rxCount <= rxCount + 16'd1;
         end
         if (misFire && (misCount != 16'hFFFF)) begin
            misCount <= misCount + 16'd1;
         end
      end
   end

   assign o_tx_count       = txCount;
   assign o_rx_count       = rxCount;
   assign o_misroute_count = misCount;
`else
   assign o_tx_count       = '0;
   assign o_rx_count       = '0;
   assign o_misroute_count = '0;
`endif
endmodule

// File: tb/tb_pe_net_iface.sv
// tb/tb_pe_net_iface.sv - scoreboard testbench for pe_net_iface

module tb_pe_net_iface;
   localparam int DW = 36;
   localparam int AW = 4;
   localparam int PW = DW - AW;
`ifdef PE_NET_IFACE_STATS_EN
   localparam bit StatsOn = 1'b1;
`else
   localparam bit StatsOn = 1'b0;
`endif

   logic          sclk = 1'b0;
   logic          rstN;
   logic [AW-1:0] peDest;
   logic [PW-1:0] pePayload;
   logic          peValid;
   logic          peReady;
   logic [DW-1:0] netDataOut;
   logic          netValidOut;
   logic          netReadyIn;
   logic [DW-1:0] netDataIn;
   logic          netValidIn;
   logic          netReadyOut;
   logic [PW-1:0] rxPayload;
   logic          rxValid;
   logic          rxReady;
   logic [15:0]   txCount;
   logic [15:0]   rxCount;
   logic [15:0]   misCount;

   int nCmp = 0;
   int nErr = 0;
   int expTx = 0;
   int expRx = 0;
   int expMis = 0;
   logic [DW-1:0] txQ[$];
   logic [PW-1:0] rxQ[$];

   always #5 sclk = ~sclk;

   pe_net_iface #(.DataWidth(DW), .AddrWidth(AW), .MyAddr(2), .TxDepth(4), .RxDepth(4)) dut (
      .i_sclk           (sclk),
      .i_reset          (rstN),
      .i_pe_dest        (peDest),
      .i_pe_payload     (pePayload),
      .i_pe_valid       (peValid),
      .o_pe_ready       (peReady),
      .o_net_data       (netDataOut),
      .o_net_valid      (netValidOut),
      .i_net_ready      (netReadyIn),
      .i_net_data       (netDataIn),
      .i_net_valid      (netValidIn),
      .o_net_ready      (netReadyOut),
      .o_pe_rx_payload  (rxPayload),
      .o_pe_rx_valid    (rxValid),
      .i_pe_rx_ready    (rxReady),
      .o_tx_count       (txCount),
      .o_rx_count       (rxCount),
      .o_misroute_count (misCount)
   );

   // Inputs change 1 time unit after the rising edge, so at the falling edge
   // a high valid/ready pair means a transfer on the coming rising edge.
   always @(negedge sclk) begin
      logic [DW-1:0] expT;
      logic [PW-1:0] expR;
      if (rstN === 1'b1) begin
         if (netValidOut && netReadyIn) begin
            nCmp++;
            if (txQ.size() == 0) begin
               nErr++;
               $display("FAIL tx_unexpected: got %h, expected no flit", netDataOut);
            end else begin
               expT = txQ.pop_front();
               if (netDataOut !== expT) begin
                  nErr++;
                  $display("FAIL tx_data: got %h, expected %h", netDataOut, expT);
               end
            end
         end
         if (rxValid && rxReady) begin
            nCmp++;
            if (rxQ.size() == 0) begin
               nErr++;
               $display("FAIL rx_unexpected: got %h, expected no payload", rxPayload);
            end else begin
               expR = rxQ.pop_front();
               if (rxPayload !== expR) begin
                  nErr++;
                  $display("FAIL rx_data: got %h, expected %h", rxPayload, expR);
               end
            end
         end
      end
   end

   task automatic sendPe(input logic [AW-1:0] d, input logic [PW-1:0] p);
      logic acc;
      acc = 1'b0;
      txQ.push_back({d, p});
      expTx++;
      peDest = d;
      pePayload = p;
      peValid = 1'b1;
      for (int i = 0; i < 60 && !acc; i++) begin
         acc = peReady;
         @(posedge sclk);
         #1;
      end
      peValid = 1'b0;
      if (!acc) begin
         nCmp++;
         nErr++;
         $display("FAIL pe_accept_timeout: got no accept, expected accept of %h", p);
      end
   endtask

   task automatic sendNet(input logic [DW-1:0] f);
      logic acc;
      acc = 1'b0;
      if (f[DW-1 -: AW] == 4'd2) begin
         rxQ.push_back(f[PW-1:0]);
         expRx++;
      end else begin
         expMis++;
      end
      netDataIn = f;
      netValidIn = 1'b1;
      for (int i = 0; i < 60 && !acc; i++) begin
         acc = netReadyOut;
         @(posedge sclk);
         #1;
      end
      netValidIn = 1'b0;
      if (!acc) begin
         nCmp++;
         nErr++;
         $display("FAIL net_accept_timeout: got no accept, expected accept of %h", f);
      end
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      peDest = '0; pePayload = '0; peValid = 1'b0;
      netReadyIn = 1'b0; netDataIn = '0; netValidIn = 1'b0; rxReady = 1'b0;
      repeat (2) @(posedge sclk);
      #1;
      nCmp++;
      if ({peReady, netReadyOut, netValidOut, rxValid} !== 4'b0000) begin
         nErr++;
         $display("FAIL reset_flags: got %b, expected 0000", {peReady, netReadyOut, netValidOut, rxValid});
      end
      nCmp++;
      if ({netDataOut, rxPayload} !== '0) begin
         nErr++;
         $display("FAIL reset_data: got %h/%h, expected 0", netDataOut, rxPayload);
      end
      rstN = 1'b1;
      @(posedge sclk);
      #1;
      nCmp++;
      if ({peReady, netReadyOut} !== 2'b11) begin
         nErr++;
         $display("FAIL ready_after_reset: got %b, expected 11", {peReady, netReadyOut});
      end
   endtask

   task automatic test_single_tx();
      netReadyIn = 1'b1;
      nCmp++;
      if (netValidOut !== 1'b0) begin
         nErr++;
         $display("FAIL single_tx_pre_valid: got %b, expected 0", netValidOut);
      end
      sendPe(4'h3, 32'hDEADBEEF);
      nCmp++;
      if (netValidOut !== 1'b1 || netDataOut !== 36'h3DEADBEEF) begin
         nErr++;
         $display("FAIL single_tx_latency: got v=%b d=%h, expected v=1 d=3deadbeef", netValidOut, netDataOut);
      end
      repeat (3) @(posedge sclk);
      #1;
      nCmp++;
      if (netValidOut !== 1'b0 || txQ.size() != 0) begin
         nErr++;
         $display("FAIL single_tx_drain: got v=%b pending=%0d, expected 0/0", netValidOut, txQ.size());
      end
   endtask

   task automatic test_backpressure();
      netReadyIn = 1'b0;
      for (int i = 1; i <= 4; i++) sendPe(AW'(i), 32'hA000_0000 + 32'(i));
      nCmp++;
      if (peReady !== 1'b0) begin
         nErr++;
         $display("FAIL tx_full_ready: got %b, expected 0", peReady);
      end
      peDest = 4'h5; pePayload = 32'hA000_0005; peValid = 1'b1;
      repeat (3) @(posedge sclk);
      #1;
      nCmp++;
      if (peReady !== 1'b0 || netDataOut !== 36'h1A0000001) begin
         nErr++;
         $display("FAIL tx_hold: got rdy=%b head=%h, expected 0/1a0000001", peReady, netDataOut);
      end
      peValid = 1'b0;
      netReadyIn = 1'b1;
      sendPe(4'h5, 32'hA000_0005);
      repeat (8) @(posedge sclk);
      #1;
      nCmp++;
      if (txQ.size() != 0 || netValidOut !== 1'b0) begin
         nErr++;
         $display("FAIL tx_bp_drain: got pending=%0d v=%b, expected 0/0", txQ.size(), netValidOut);
      end
   endtask

   task automatic test_rx_match();
      rxReady = 1'b1;
      sendNet(36'h2_0000_0011);
      sendNet(36'h5_0000_0022);
      repeat (4) @(posedge sclk);
      #1;
      nCmp++;
      if (rxQ.size() != 0 || rxValid !== 1'b0) begin
         nErr++;
         $display("FAIL rx_match_drain: got pending=%0d v=%b, expected 0/0", rxQ.size(), rxValid);
      end
      nCmp++;
      if (rxCount !== 16'(StatsOn ? 1 : 0) || misCount !== 16'(StatsOn ? 1 : 0)) begin
         nErr++;
         $display("FAIL rx_match_counts: got rx=%0d mis=%0d, expected %0d/%0d", rxCount, misCount,
                  StatsOn ? 1 : 0, StatsOn ? 1 : 0);
      end
   endtask

   task automatic test_rx_full();
      rxReady = 1'b0;
      for (int i = 0; i < 4; i++) sendNet({4'h2, 32'h0000_0100 + 32'(i)});
      nCmp++;
      if (netReadyOut !== 1'b0 || rxValid !== 1'b1 || rxPayload !== 32'h0000_0100) begin
         nErr++;
         $display("FAIL rx_full: got rdy=%b v=%b head=%h, expected 0/1/00000100", netReadyOut, rxValid, rxPayload);
      end
      rxReady = 1'b1;
      @(posedge sclk);
      #1;
      rxReady = 1'b0;
      nCmp++;
      if (netReadyOut !== 1'b1) begin
         nErr++;
         $display("FAIL rx_ready_after_pop: got %b, expected 1", netReadyOut);
      end
      rxReady = 1'b1;
      repeat (6) @(posedge sclk);
      #1;
      nCmp++;
      if (rxQ.size() != 0) begin
         nErr++;
         $display("FAIL rx_full_drain: got pending=%0d, expected 0", rxQ.size());
      end
   endtask

   task automatic test_back_to_back();
      fork
         begin
            for (int i = 0; i < 16; i++) sendPe(AW'($urandom_range(0, 15)), PW'($urandom));
         end
         begin
            for (int j = 0; j < 16; j++) begin
               logic [AW-1:0] a;
               a = ($urandom_range(0, 2) == 0) ? AW'($urandom_range(0, 15)) : 4'h2;
               sendNet({a, PW'($urandom)});
            end
         end
         begin
            for (int k = 0; k < 150; k++) begin
               @(posedge sclk);
               #1;
               netReadyIn = 1'($urandom_range(0, 1));
               rxReady = 1'($urandom_range(0, 1));
            end
         end
      join
      netReadyIn = 1'b1;
      rxReady = 1'b1;
      repeat (10) @(posedge sclk);
      #1;
      nCmp++;
      if (txQ.size() != 0 || rxQ.size() != 0) begin
         nErr++;
         $display("FAIL b2b_drain: got tx=%0d rx=%0d pending, expected 0/0", txQ.size(), rxQ.size());
      end
      nCmp++;
      if (txCount !== 16'(StatsOn ? expTx : 0) || rxCount !== 16'(StatsOn ? expRx : 0)
          || misCount !== 16'(StatsOn ? expMis : 0)) begin
         nErr++;
         $display("FAIL b2b_counts: got %0d/%0d/%0d, expected %0d/%0d/%0d", txCount, rxCount, misCount,
                  StatsOn ? expTx : 0, StatsOn ? expRx : 0, StatsOn ? expMis : 0);
      end
   endtask

   task automatic test_reset_mid();
      netReadyIn = 1'b0;
      rxReady = 1'b0;
      for (int i = 0; i < 3; i++) sendPe(4'h7, 32'hC000_0000 + 32'(i));
      for (int i = 0; i < 3; i++) sendNet({4'h2, 32'hB000_0000 + 32'(i)});
      nCmp++;
      if ({netValidOut, rxValid} !== 2'b11) begin
         nErr++;
         $display("FAIL mid_buffered: got %b, expected 11", {netValidOut, rxValid});
      end
      #2;
      rstN = 1'b0;
      txQ.delete();
      rxQ.delete();
      expTx = 0; expRx = 0; expMis = 0;
      #1;
      nCmp++;
      if ({netValidOut, rxValid, peReady, netReadyOut} !== 4'b0000 || {txCount, rxCount, misCount} !== '0) begin
         nErr++;
         $display("FAIL mid_async_reset: got flags=%b cnt=%h, expected 0000/0",
                  {netValidOut, rxValid, peReady, netReadyOut}, {txCount, rxCount, misCount});
      end
      @(posedge sclk);
      #1;
      rstN = 1'b1;
      netReadyIn = 1'b1;
      rxReady = 1'b1;
      repeat (5) @(posedge sclk);
      #1;
      nCmp++;
      if ({netValidOut, rxValid} !== 2'b00 || {peReady, netReadyOut} !== 2'b11) begin
         nErr++;
         $display("FAIL mid_after_release: got v=%b rdy=%b, expected 00/11",
                  {netValidOut, rxValid}, {peReady, netReadyOut});
      end
      sendPe(4'h1, 32'h1234_5678);
      sendNet(36'h2_8765_4321);
      repeat (4) @(posedge sclk);
      #1;
      nCmp++;
      if (txQ.size() != 0 || rxQ.size() != 0 || txCount !== 16'(StatsOn ? 1 : 0)
          || rxCount !== 16'(StatsOn ? 1 : 0)) begin
         nErr++;
         $display("FAIL mid_fresh_traffic: got pend=%0d/%0d cnt=%0d/%0d, expected 0/0 and %0d/%0d",
                  txQ.size(), rxQ.size(), txCount, rxCount, StatsOn ? 1 : 0, StatsOn ? 1 : 0);
      end
   endtask

   initial begin
      test_reset();
      test_single_tx();
      test_backpressure();
      test_rx_match();
      test_rx_full();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end
endmodule

// File: doc/pe_net_iface.md
PE_NET_IFACE -- requirements
Module: pe_net_iface

Interface
REQ-001 SHALL have parameter DataWidth, default 36, flit width including address field.
REQ-002 SHALL have parameter AddrWidth, default 4, destination address field width at flit bits [DataWidth-1 -: AddrWidth].
REQ-003 SHALL have parameter MyAddr, default 0, this endpoint's network address.
REQ-004 SHALL have parameter TxDepth, default 4, tx FIFO entries (power of two, >=2).
REQ-005 SHALL have parameter RxDepth, default 4, rx FIFO entries (power of two, >=2).
REQ-006 i_sclk  input  1  sole clock; all state on rising edge.
REQ-007 i_reset  input  1  asynchronous, active-low reset.
REQ-008 i_pe_dest  input  AddrWidth  destination address for tx word.
REQ-009 i_pe_payload  input  DataWidth-AddrWidth  tx payload.
REQ-010 i_pe_valid / o_pe_ready  input / output  1 each  PE tx handshake.
REQ-011 o_net_data / o_net_valid / i_net_ready  output / output / input  DataWidth / 1 / 1  flit toward switch port.
REQ-012 i_net_data / i_net_valid / o_net_ready  input / input / output  DataWidth / 1 / 1  flit from switch port.
REQ-013 o_pe_rx_payload / o_pe_rx_valid / i_pe_rx_ready  output / output / input  DataWidth-AddrWidth / 1 / 1  PE rx handshake.
REQ-014 o_tx_count, o_rx_count, o_misroute_count  output  16 each  statistics.

Function
REQ-015 Transfer on any valid/ready pair SHALL occur exactly on a clock edge where both are high; senders hold valid and data stable until transfer.
REQ-016 Tx path SHALL push flit {i_pe_dest, i_pe_payload} into tx FIFO on PE transfer; o_pe_ready = tx FIFO not full (no same-cycle pop-through when full).
REQ-017 o_net_valid SHALL equal tx FIFO not empty; o_net_data SHALL be the FIFO head, registered; pop on net transfer.
REQ-018 Tx latency SHALL be 1 cycle: word accepted at edge N into empty FIFO is presented with o_net_valid high after edge N.
REQ-019 Simultaneous push and pop SHALL keep occupancy unchanged; pointers wrap modulo depth; occupancy range 0..depth.
REQ-020 o_net_ready SHALL equal rx FIFO not full.
REQ-021 Received flit with address field == MyAddr SHALL push its payload into rx FIFO; otherwise flit SHALL still be accepted, dropped, and counted as misroute.
REQ-022 o_pe_rx_valid = rx FIFO not empty; o_pe_rx_payload = head; pop on PE rx transfer; rx latency 1 cycle.
REQ-023 Tx and rx paths SHALL be fully independent; no ordering or blocking between them.
REQ-024 Statistics counters SHALL increment by 1 per net tx transfer, per accepted matching rx flit, per dropped misroute flit; saturate at 16'hFFFF.

Reset
REQ-025 While i_reset low, asynchronously: both FIFOs empty, pointers 0, o_net_valid=0, o_pe_rx_valid=0, o_pe_ready=0, o_net_ready=0, counters 0, data outputs 0.
REQ-026 o_pe_ready and o_net_ready SHALL assert on the first edge after reset deasserts; reset mid-operation SHALL discard all buffered flits with no partial transfer.

Configuration
REQ-027 Macro PE_NET_IFACE_STATS_EN: when defined, counters of REQ-024 are built; when undefined, no counter registers exist and the three count outputs are constant 0; datapath behaviour is identical either way.

Verification
REQ-028 Single tx: dest=4'h3, payload=32'hDEADBEEF, net ready=1 -> o_net_data=36'h3DEADBEEF valid exactly one cycle after accept.
REQ-029 Tx backpressure: i_net_ready=0, push 5 words with TxDepth=4 -> 4 accepted, o_pe_ready low on 5th; release ready -> 4 flits out in order, then 5th.
REQ-030 Rx match/misroute: MyAddr=2, send 36'h2_0000_0011 then 36'h5_0000_0022 -> only payload 32'h00000011 delivered; rx_count=1, misroute_count=1 (0 with macro undefined).
REQ-031 Rx full: i_pe_rx_ready=0, 4 matching flits -> o_net_ready low after 4th; one PE pop -> o_net_ready high next cycle.
REQ-032 Reset mid-operation: 3 flits buffered in each FIFO, pulse i_reset low asynchronously -> all valids and counters 0 immediately, no stale flit after release.
